// File: rtl/pixel_stream_fifo.sv
// Elastic pixel buffer ahead of display_system: valid/ready write side, 1-cycle registered pop per pix_req,
// s_ready drops at full or during flush. Optional PIXEL_FIFO_UNDERFLOW_REPEAT_EN repeats the last pixel on underflow.
module pixel_stream_fifo #(
   parameter  int DEPTH  = 16,
   parameter  int DATA_W = 24,
   localparam int LW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              flush,
   input  logic              pix_req,
   output logic [DATA_W-1:0] pixel_data,
   output logic              pix_valid,
   output logic              underflow,
   input  logic              underflow_clr,
   output logic [15:0]       underflow_cnt,
   output logic [LW-1:0]     level
);

   localparam int            AW       = LW - 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

`ifdef PIXEL_FIFO_UNDERFLOW_REPEAT_EN
   localparam bit UF_BLACK = 1'b0;
`else
   localparam bit UF_BLACK = 1'b1;
`endif

   logic [DATA_W-1:0] mem [DEPTH];
   logic [LW-1:0]     wr_ptr;
   logic [LW-1:0]     rd_ptr;
   logic              wr_en;
   logic              pop;
   logic              uf_evt;
   logic              empty;

   // Pointers carry one extra MSB so full and empty differ at equal indices.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign s_ready = (level != FULL_LVL) && !flush;
   assign wr_en   = s_valid && s_ready;
   assign pop     = pix_req && !empty && !flush;
   assign uf_evt  = pix_req && (empty || flush);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // With the repeat build, holding pixel_data on underflow equals replaying the last popped pixel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pixel_data <= '0;
         pix_valid  <= 1'b0;
      end else begin
         pix_valid <= pop;
         if (pop) begin
            pixel_data <= mem[rd_ptr[AW-1:0]];
         end else if (uf_evt && UF_BLACK) begin
            pixel_data <= '0;
         end
      end
   end

   // A clear coinciding with a new underflow keeps the new event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else if (underflow_clr) begin
         underflow     <= uf_evt;
         underflow_cnt <= {15'd0, uf_evt};
      end else if (uf_evt) begin
         underflow <= 1'b1;
         if (underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Directed table-driven bench for pixel_stream_fifo (DEPTH 16), plus a hand sequence for async reset mid-fill.
module tb_pixel_stream_fifo;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 24;
   localparam int LW     = $clog2(DEPTH) + 1;

`ifdef PIXEL_FIFO_UNDERFLOW_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   typedef struct {
      logic              sv;
      logic [DATA_W-1:0] sd;
      logic              req;
      logic              fl;
      logic              clr;
      logic [LW-1:0]     e_lvl;
      logic              e_rdy;
      logic              e_pv;
      logic [DATA_W-1:0] e_pd;
      logic              e_uf;
      logic [15:0]       e_cnt;
   } vec_t;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              flush;
   logic              pix_req;
   logic [DATA_W-1:0] pixel_data;
   logic              pix_valid;
   logic              underflow;
   logic              underflow_clr;
   logic [15:0]       underflow_cnt;
   logic [LW-1:0]     level;

   int   checks;
   int   errors;
   int   cur_idx;
   vec_t tbl[$];

   pixel_stream_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .flush        (flush),
      .pix_req      (pix_req),
      .pixel_data   (pixel_data),
      .pix_valid    (pix_valid),
      .underflow    (underflow),
      .underflow_clr(underflow_clr),
      .underflow_cnt(underflow_cnt),
      .level        (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got %h, expected %h", name, cur_idx, act, exp);
      end
   endtask

   task automatic add(input logic sv, input logic [DATA_W-1:0] sd, input logic req, input logic fl,
                      input logic clr, input int lvl, input logic rdy, input logic pv,
                      input logic [DATA_W-1:0] pd, input logic uf, input int cnt);
      vec_t v;
      v.sv = sv; v.sd = sd; v.req = req; v.fl = fl; v.clr = clr;
      v.e_lvl = LW'(lvl); v.e_rdy = rdy; v.e_pv = pv; v.e_pd = pd;
      v.e_uf = uf; v.e_cnt = 16'(cnt);
      tbl.push_back(v);
   endtask

   task automatic idle_inputs();
      s_valid = 1'b0; s_data = '0; pix_req = 1'b0; flush = 1'b0; underflow_clr = 1'b0;
   endtask

   task automatic check_outs(input vec_t v);
      chk("level", 32'(level), 32'(v.e_lvl));
      chk("s_ready", 32'(s_ready), 32'(v.e_rdy));
      chk("pix_valid", 32'(pix_valid), 32'(v.e_pv));
      chk("pixel_data", 32'(pixel_data), 32'(v.e_pd));
      chk("underflow", 32'(underflow), 32'(v.e_uf));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(v.e_cnt));
   endtask

   // Called at a falling edge; drives one cycle, then compares at the next falling edge.
   task automatic apply(input vec_t v);
      s_valid = v.sv; s_data = v.sd; pix_req = v.req; flush = v.fl; underflow_clr = v.clr;
      @(posedge clk);
      #1 idle_inputs();
      @(negedge clk);
      check_outs(v);
   endtask

   initial begin
      logic [DATA_W-1:0] pat [3];
      logic [DATA_W-1:0] ufpd;
      vec_t              v;
      checks = 0;
      errors = 0;
      cur_idx = -1;
      pat[0] = 24'hFF0000; pat[1] = 24'h00FF00; pat[2] = 24'h0000FF;
      ufpd = REP ? 24'h00FF00 : 24'h000000;

      // Fill to full, then a rejected 17th write.
      for (int i = 1; i <= 16; i++) add(1, 24'(i), 0, 0, 0, i, i != 16, 0, 0, 0, 0);
      add(1, 24'h000011, 0, 0, 0, 16, 0, 0, 0, 0, 0);
      // Ordered drain.
      for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 0, 16 - i, 1, 1, 24'(i), 0, 0);
      // Streaming at level 2.
      add(1, pat[0], 0, 0, 0, 1, 1, 0, 24'h000010, 0, 0);
      add(1, pat[1], 0, 0, 0, 2, 1, 0, 24'h000010, 0, 0);
      for (int k = 0; k < 99; k++) add(1, pat[(k + 2) % 3], 1, 0, 0, 2, 1, 1, pat[k % 3], 0, 0);
      add(0, 0, 1, 0, 0, 1, 1, 1, pat[0], 0, 0);
      add(0, 0, 1, 0, 0, 0, 1, 1, pat[1], 0, 0);
      // Underflow x3, clear, clear colliding with an underflow, clear.
      for (int n = 1; n <= 3; n++) add(0, 0, 1, 0, 0, 0, 1, 0, ufpd, 1, n);
      add(0, 0, 0, 0, 1, 0, 1, 0, ufpd, 0, 0);
      add(0, 0, 1, 0, 1, 0, 1, 0, ufpd, 1, 1);
      add(0, 0, 0, 0, 1, 0, 1, 0, ufpd, 0, 0);
      // Flush at level 5 with concurrent write and request.
      for (int i = 1; i <= 5; i++) add(1, 24'hA00000 + 24'(i), 0, 0, 0, i, 1, 0, ufpd, 0, 0);
      add(1, 24'hBADBAD, 1, 1, 0, 0, 1, 0, ufpd, 1, 1);
      add(1, 24'h123456, 0, 0, 0, 1, 1, 0, ufpd, 1, 1);
      add(0, 0, 1, 0, 0, 0, 1, 1, 24'h123456, 1, 1);
      // Build to level 7 with a non-zero pixel_data ahead of the mid-run reset.
      for (int i = 1; i <= 8; i++) add(1, 24'hC00000 + 24'(i), 0, 0, 0, i, 1, 0, 24'h123456, 1, 1);
      add(0, 0, 1, 0, 0, 7, 1, 1, 24'hC00001, 1, 1);

      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      v.e_lvl = '0; v.e_rdy = 1'b1; v.e_pv = 1'b0; v.e_pd = '0; v.e_uf = 1'b0; v.e_cnt = '0;
      check_outs(v);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cur_idx = i;
         apply(tbl[i]);
      end

      // Asynchronous reset between edges at level 7.
      cur_idx = 1000;
      #2 rst_n = 1'b0;
      #1 check_outs(v);
      s_valid = 1'b1; s_data = 24'hDEAD01;
      @(posedge clk);
      #1 idle_inputs();
      cur_idx = 1001;
      chk("level_in_reset", 32'(level), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cur_idx = 1002;
      v.sv = 1'b1; v.sd = 24'h5A5A5A; v.req = 1'b0; v.fl = 1'b0; v.clr = 1'b0;
      v.e_lvl = LW'(1); v.e_rdy = 1'b1; v.e_pv = 1'b0; v.e_pd = '0; v.e_uf = 1'b0; v.e_cnt = '0;
      apply(v);
      cur_idx = 1003;
      v.sv = 1'b0; v.sd = '0; v.req = 1'b1;
      v.e_lvl = '0; v.e_pv = 1'b1; v.e_pd = 24'h5A5A5A;
      apply(v);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
